// File: rtl/safe_auth_ctrl_pkg.sv
// Shared types and constants for the safe authentication sequencer.
package safe_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    CHECK,
    LOCKOUT
  } state_t;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam logic [3:0]  BLANK   = 4'hF;

endpackage

// File: rtl/safe_auth_ctrl_debounce.sv
// Level debouncer with a registered single-cycle rising-edge event.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYC - 1);

  logic [7:0] cnt;

  // Count consecutive disagreeing cycles; flip the level once the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else if (din != level) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        level <= din;
        rise  <= din;
      end else begin
        cnt   <= cnt + 8'd1;
        rise  <= 1'b0;
      end
    end else begin
      cnt  <= '0;
      rise <= 1'b0;
    end
  end

endmodule

// File: rtl/safe_auth_ctrl.sv
// Authentication sequencer: debounced keypad entry, password check, attempt limit and timed lockout.
module safe_auth_ctrl
  import safe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned LOCK_TICKS   = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        bksp,
  input  logic        cnf,
  input  logic        tick,
  input  logic [15:0] pw,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic        match_pulse,
  output logic        fail_pulse,
  output logic        locked,
  output logic [1:0]  attempts_left,
  output logic [7:0]  lock_remain
);

  localparam logic [1:0] ATT_MAX  = 2'(MAX_ATTEMPTS);
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_TICKS);

  logic key_lvl, bksp_lvl, cnf_lvl;
  logic key_ev, bksp_ev, cnf_ev;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .clk(clk), .rst_n(rst_n), .din(key_valid), .level(key_lvl), .rise(key_ev)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_bksp (
    .clk(clk), .rst_n(rst_n), .din(bksp), .level(bksp_lvl), .rise(bksp_ev)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cnf (
    .clk(clk), .rst_n(rst_n), .din(cnf), .level(cnf_lvl), .rise(cnf_ev)
  );

  // Only the edge events drive the sequencer; the filtered levels are not needed here.
  logic unused_levels;
  assign unused_levels = ^{key_lvl, bksp_lvl, cnf_lvl};

  state_t      state_q, state_d;
  logic [15:0] entry_d;
  logic [2:0]  cnt_d;
  logic [1:0]  att_d;
  logic        locked_d;
  logic [7:0]  remain_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ENTRY;
      entry         <= '1;
      digit_cnt     <= '0;
      attempts_left <= ATT_MAX;
      locked        <= 1'b0;
      lock_remain   <= '0;
    end else begin
      state_q       <= state_d;
      entry         <= entry_d;
      digit_cnt     <= cnt_d;
      attempts_left <= att_d;
      locked        <= locked_d;
      lock_remain   <= remain_d;
    end
  end

  // Next-state, buffer edits and check pulses; events are prioritised cnf > bksp > digit.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry;
    cnt_d       = digit_cnt;
    att_d       = attempts_left;
    locked_d    = locked;
    remain_d    = lock_remain;
    match_pulse = 1'b0;
    fail_pulse  = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (cnf_ev) begin
          if (digit_cnt == 3'(DIGITS)) state_d = CHECK;
        end else if (bksp_ev) begin
          if (digit_cnt != 3'd0) begin
            entry_d = {BLANK, entry[15:DIGIT_W]};
            cnt_d   = digit_cnt - 3'd1;
          end
        end else if (key_ev) begin
          if (digit_cnt < 3'(DIGITS) && key_code <= 4'd9) begin
            entry_d = {entry[15-DIGIT_W:0], key_code};
            cnt_d   = digit_cnt + 3'd1;
          end
        end
      end
      CHECK: begin
        entry_d = '1;
        cnt_d   = '0;
        state_d = ENTRY;
        if (entry == pw) begin
          match_pulse = 1'b1;
          att_d       = ATT_MAX;
        end else begin
          fail_pulse = 1'b1;
          att_d      = attempts_left - 2'd1;
          if (attempts_left == 2'd1) begin
            locked_d = 1'b1;
            remain_d = LOCK_MAX;
            state_d  = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (lock_remain == 8'd1) begin
            remain_d = '0;
            locked_d = 1'b0;
            att_d    = ATT_MAX;
            state_d  = ENTRY;
          end else begin
            remain_d = lock_remain - 8'd1;
          end
        end
      end
      default: state_d = ENTRY;
    endcase
  end

endmodule

// File: tb/tb_safe_auth_ctrl.sv
// Scoreboard bench for safe_auth_ctrl: stimulus queues expected output snapshots, a monitor
// compares every observed change of the output bundle against the queue head.
module tb_safe_auth_ctrl;

  typedef struct packed {
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        m;
    logic        f;
    logic        lk;
    logic [1:0]  att;
    logic [7:0]  rem;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        bksp = 1'b0;
  logic        cnf = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] pw = 16'h2301;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        match_pulse, fail_pulse, locked;
  logic [1:0]  attempts_left;
  logic [7:0]  lock_remain;

  int    ncmp = 0;
  int    nbad = 0;
  snap_t q[$];
  snap_t prev;
  logic  prev_m = 1'b0;
  logic  prev_f = 1'b0;

  safe_auth_ctrl #(.DEBOUNCE_CYC(4), .MAX_ATTEMPTS(3), .LOCK_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .bksp(bksp), .cnf(cnf), .tick(tick), .pw(pw), .entry(entry),
    .digit_cnt(digit_cnt), .match_pulse(match_pulse), .fail_pulse(fail_pulse),
    .locked(locked), .attempts_left(attempts_left), .lock_remain(lock_remain)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input snap_t s);
    return $sformatf("entry=%h cnt=%0d m=%0d f=%0d lk=%0d att=%0d rem=%0d",
                     s.entry, s.cnt, s.m, s.f, s.lk, s.att, s.rem);
  endfunction

  function automatic void push(input logic [15:0] e, input logic [2:0] n, input logic m,
                               input logic f, input logic lk, input logic [1:0] a,
                               input logic [7:0] r);
    q.push_back('{entry: e, cnt: n, m: m, f: f, lk: lk, att: a, rem: r});
  endfunction

  // Monitor: sample mid-cycle, compare on every change of the output bundle.
  always @(negedge clk) begin
    snap_t cur, exp_s;
    if (rst_n) begin
      cur = '{entry: entry, cnt: digit_cnt, m: match_pulse, f: fail_pulse, lk: locked,
              att: attempts_left, rem: lock_remain};
      if (prev_m || prev_f) begin
        ncmp++;
        if (match_pulse || fail_pulse) begin
          nbad++;
          $display("FAIL pulse_width: got m=%0d f=%0d, required both 0 after a pulse",
                   match_pulse, fail_pulse);
        end
      end
      if (cur != prev) begin
        ncmp++;
        if (q.size() == 0) begin
          nbad++;
          $display("FAIL unexpected_change: got %s, required no change", fmt(cur));
        end else begin
          exp_s = q.pop_front();
          if (cur != exp_s) begin
            nbad++;
            $display("FAIL snapshot: got %s, required %s", fmt(cur), fmt(exp_s));
          end
        end
        prev = cur;
      end
      prev_m = match_pulse;
      prev_f = fail_pulse;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    key_code = c;
    key_valid = 1'b1;
    idle(6);
    key_valid = 1'b0;
    idle(6);
  endtask

  task automatic press_bksp();
    bksp = 1'b1;
    idle(6);
    bksp = 1'b0;
    idle(6);
  endtask

  task automatic press_cnf();
    cnf = 1'b1;
    idle(6);
    cnf = 1'b0;
    idle(6);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    idle(1);
    tick = 1'b0;
    idle(3);
  endtask

  // Four 9s then confirm against pw=2301; attempt count shown in CHECK is the old value.
  task automatic wrong_code(input logic [1:0] a_old, input logic [1:0] a_new,
                            input logic lk_new, input logic [7:0] rem_new);
    push(16'hFFF9, 3'd1, 0, 0, 0, a_old, 8'd0); key(4'd9);
    push(16'hFF99, 3'd2, 0, 0, 0, a_old, 8'd0); key(4'd9);
    push(16'hF999, 3'd3, 0, 0, 0, a_old, 8'd0); key(4'd9);
    push(16'h9999, 3'd4, 0, 0, 0, a_old, 8'd0); key(4'd9);
    push(16'h9999, 3'd4, 0, 1, 0, a_old, 8'd0);
    push(16'hFFFF, 3'd0, 0, 0, lk_new, a_new, rem_new);
    press_cnf();
  endtask

  initial begin
    prev = '{entry: 16'h0000, cnt: 3'd7, m: 1'b0, f: 1'b0, lk: 1'b0, att: 2'd0, rem: 8'd0};
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);

    pulse_tick();

    push(16'hFFF2, 3'd1, 0, 0, 0, 2'd3, 8'd0); key(4'd2);
    push(16'hFF23, 3'd2, 0, 0, 0, 2'd3, 8'd0); key(4'd3);
    push(16'hF230, 3'd3, 0, 0, 0, 2'd3, 8'd0); key(4'd0);
    push(16'h2301, 3'd4, 0, 0, 0, 2'd3, 8'd0); key(4'd1);
    push(16'h2301, 3'd4, 1, 0, 0, 2'd3, 8'd0);
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0);
    press_cnf();

    key_code = 4'd7;
    key_valid = 1'b1;
    idle(3);
    key_valid = 1'b0;
    idle(8);

    push(16'hFFF5, 3'd1, 0, 0, 0, 2'd3, 8'd0); key(4'd5);
    push(16'hFF56, 3'd2, 0, 0, 0, 2'd3, 8'd0); key(4'd6);
    push(16'hFFF5, 3'd1, 0, 0, 0, 2'd3, 8'd0); press_bksp();
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0); press_bksp();
    press_bksp();

    push(16'hFFF1, 3'd1, 0, 0, 0, 2'd3, 8'd0); key(4'd1);
    push(16'hFF12, 3'd2, 0, 0, 0, 2'd3, 8'd0); key(4'd2);
    push(16'hF123, 3'd3, 0, 0, 0, 2'd3, 8'd0); key(4'd3);
    key(4'd12);
    press_cnf();
    push(16'h1234, 3'd4, 0, 0, 0, 2'd3, 8'd0); key(4'd4);
    key(4'd5);
    push(16'hF123, 3'd3, 0, 0, 0, 2'd3, 8'd0); press_bksp();
    push(16'hFF12, 3'd2, 0, 0, 0, 2'd3, 8'd0); press_bksp();
    push(16'hFFF1, 3'd1, 0, 0, 0, 2'd3, 8'd0); press_bksp();
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0); press_bksp();

    wrong_code(2'd3, 2'd2, 1'b0, 8'd0);
    wrong_code(2'd2, 2'd1, 1'b0, 8'd0);
    wrong_code(2'd1, 2'd0, 1'b1, 8'd3);

    key(4'd5);
    press_bksp();
    press_cnf();

    push(16'hFFFF, 3'd0, 0, 0, 1, 2'd0, 8'd2); pulse_tick();
    push(16'hFFFF, 3'd0, 0, 0, 1, 2'd0, 8'd1); pulse_tick();
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0); pulse_tick();
    pulse_tick();

    push(16'hFFF2, 3'd1, 0, 0, 0, 2'd3, 8'd0); key(4'd2);
    pw = 16'h5555;
    push(16'hFF23, 3'd2, 0, 0, 0, 2'd3, 8'd0); key(4'd3);
    pw = 16'h2301;
    push(16'hF230, 3'd3, 0, 0, 0, 2'd3, 8'd0); key(4'd0);
    push(16'h2301, 3'd4, 0, 0, 0, 2'd3, 8'd0); key(4'd1);
    push(16'h2301, 3'd4, 1, 0, 0, 2'd3, 8'd0);
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0);
    press_cnf();

    push(16'hFFF8, 3'd1, 0, 0, 0, 2'd3, 8'd0); key(4'd8);
    push(16'hFFFF, 3'd0, 0, 0, 0, 2'd3, 8'd0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10);

    ncmp++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL pending_expect: got %0d unobserved snapshots, required 0 (next %s)",
               q.size(), fmt(q[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/safe_auth_ctrl.md
Name: safe_auth_ctrl

Overview:
- Authentication sequencer for the digital safe.
- Takes the raw keypad-present/encoded-digit pair plus backspace and confirm buttons, and debounces them into single-cycle events.
- Assembles a 4-digit entry buffer and compares it against the stored password.
- Owns the attempt counter and a timed lockout, so the top-level FSM only handles logged-in and password-reset flow. Runs on the fast system clock; `tick` is an external timebase strobe.

Parameters:
- DEBOUNCE_CYC, 4, consecutive stable cycles required before an input level change is accepted (1..255).
- MAX_ATTEMPTS, 3, wrong confirms allowed before lockout (1..3).
- LOCK_TICKS, 30, lockout duration in `tick` pulses (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key_valid  in  1  high while any keypad key is held.
- key_code  in  4  encoded digit, sampled at the accept event; values >9 are ignored.
- bksp  in  1  backspace button level.
- cnf  in  1  confirm button level.
- tick  in  1  one-cycle timebase strobe.
- pw  in  16  stored password, digit 3 in [15:12], digit 0 in [3:0].
- entry  out  16  entry buffer for display; 4'hF = blank digit.
- digit_cnt  out  3  digits entered, 0..4.
- match_pulse  out  1  one-cycle pulse on correct code.
- fail_pulse  out  1  one-cycle pulse on wrong code.
- locked  out  1  high during lockout.
- attempts_left  out  2  remaining attempts.
- lock_remain  out  8  ticks left in lockout, 0 otherwise.

Behaviour:
- Reset values (async on rst_n low):
  - entry=16'hFFFF, digit_cnt=0, attempts_left=MAX_ATTEMPTS.
  - locked=0, lock_remain=0, match_pulse=0, fail_pulse=0.
  - state=ENTRY; all debounce filters cleared to 0.
- Debounce, per input (key_valid, bksp, cnf):
  - A counter counts consecutive cycles in which the raw input differs from the filtered level, and clears when they agree.
  - When the count reaches DEBOUNCE_CYC, the filtered level flips.
  - A filtered 0->1 transition produces a registered one-cycle event. With an input held high from cycle 0, the event is high in cycle DEBOUNCE_CYC.
  - A new press event requires a filtered release first. Holding a key gives exactly one event.
- key_code is captured in the event cycle. The entry buffer updates one cycle after the event.
- Event priority within a cycle: cnf > bksp > digit. Lower-priority events in that cycle are dropped.
- State ENTRY:
  - Digit with digit_cnt<4: entry <= {entry[11:0],code}, digit_cnt+1.
  - Digit with digit_cnt==4, or code>9: ignored.
  - bksp with digit_cnt>0: entry <= {4'hF,entry[15:4]}, digit_cnt-1. With digit_cnt==0: ignored.
  - cnf with digit_cnt==4: go to CHECK. With digit_cnt<4: ignored, no attempt consumed.
- State CHECK (exactly one cycle):
  - In all cases entry <= FFFF and digit_cnt <= 0.
  - entry==pw: match_pulse=1 for one cycle, attempts_left <= MAX_ATTEMPTS, go to ENTRY.
  - Mismatch: fail_pulse=1 for one cycle, attempts_left-1. If the result is 0: locked <= 1, lock_remain <= LOCK_TICKS, go to LOCKOUT. Otherwise go to ENTRY.
- State LOCKOUT:
  - All key, bksp and cnf events are discarded; the filters keep running.
  - Each tick decrements lock_remain.
  - A tick while lock_remain==1: lock_remain <= 0, locked <= 0, attempts_left <= MAX_ATTEMPTS, go to ENTRY.
  - tick is ignored outside LOCKOUT.
- pw is sampled only in CHECK. A pw change mid-entry has no other effect.
- Reset mid-lockout or mid-entry returns to the reset values immediately. Lockout does not persist across reset.

Decomposition:
- Package safe_pkg holds:
  - state enum {ENTRY, CHECK, LOCKOUT}.
  - localparam DIGITS=4, BLANK=4'hF, DIGIT_W=4.
- Sub-module key_debounce (params DEBOUNCE_CYC; ports clk, rst_n, din, level, rise), instantiated three times.

Test Plan (DEBOUNCE_CYC=4, MAX_ATTEMPTS=3, LOCK_TICKS=3, pw=16'h2301):
- Reset release -> entry=16'hFFFF, digit_cnt=0, attempts_left=3, locked=0, all pulses 0.
- Keys 2,3,0,1 (each held 6 cycles, released 6 cycles), then cnf -> entry passes FFF2, FF23, F230, 2301. One cycle after the cnf event, match_pulse=1 for exactly one cycle. Then entry=FFFF, attempts_left=3.
- key_valid high 3 cycles then low (glitch) -> no event, entry unchanged.
- Keys 5,6 then bksp -> entry=FFF5, digit_cnt=1. Two more bksp -> entry=FFFF, digit_cnt=0 (second ignored).
- cnf at digit_cnt=3 -> no pulse, attempts_left stays 3. Fifth digit after 4 entered -> ignored.
- Three wrong codes (9999) -> fail_pulse ×3, attempts_left 2,1,0. After the third: locked=1, lock_remain=3, and key presses are ignored. Three ticks -> lock_remain 2,1,0, locked=0, attempts_left=3.
